muon_buf_readout_ctrl: RTL and testbench

Sequences readout of filled muon buffers from the dual-port muon memory (read port) to a 64-bit valid/ready stream toward the DMA/PS side. Watches the muon buffer full count and read pointer, reads exactly the recorded word count of the current read buffer, then issues the release strobe that clears that buffer's full flag. Sits between the muon buffer loader's status outputs and the muon memory read port, in the CLK120 domain.

---
 rtl/muon_buf_readout_ctrl.sv | 276 +++++++++++++++++++++++++++
 tb/tb_muon_buf_readout_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muon_buf_readout_ctrl.sv
// muon_buf_readout_ctrl
// Reads filled muon buffers out of the muon memory read port, in CLK120, and
// presents them as a 64-bit valid/ready stream. Each buffer's recorded word
// count is latched, exactly that many words are read, and then RELEASE frees
// the buffer back to the loader.
// Optional build macro: MUON_RDOUT_HDR_EN (adds two header words per buffer).
module muon_buf_readout_ctrl #(
    parameter int unsigned BUF_NUM_WIDTH = 2,
    parameter int unsigned MEM_BUF_SHIFT = 11,
    parameter int unsigned WC_WIDTH      = 12,
    parameter int unsigned MEM_LATENCY   = 2,
    parameter int unsigned ACK_TIMEOUT   = 1023
) (
    input  logic                                   CLK120,
    input  logic                                   RESET_N,
    input  logic                                   ENABLE,
    input  logic [BUF_NUM_WIDTH:0]                 BUF_NFULL,
    input  logic [BUF_NUM_WIDTH-1:0]               BUF_RNUM,
    input  logic [WC_WIDTH-1:0]                    BUF_WORD_COUNT,
    input  logic [31:0]                            TIME_TAG_A,
    input  logic [31:0]                            TIME_TAG_B,
    output logic                                   MEM_EN,
    output logic [BUF_NUM_WIDTH+MEM_BUF_SHIFT-1:0] MEM_ADDR,
    input  logic [31:0]                            MEM_DATA0,
    input  logic [31:0]                            MEM_DATA1,
    output logic [63:0]                            OUT_DATA,
    output logic                                   OUT_VALID,
    input  logic                                   OUT_READY,
    output logic                                   OUT_LAST,
    output logic                                   RELEASE,
    output logic [BUF_NUM_WIDTH-1:0]               RELEASE_BUFNUM,
    output logic                                   BUSY,
    output logic                                   ACK_ERR
);

    localparam int unsigned CW    = MEM_BUF_SHIFT + 1;
    localparam int unsigned WMAX  = 1 << MEM_BUF_SHIFT;
    localparam int unsigned DEPTH = MEM_LATENCY + 2;
    localparam int unsigned PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned FCW   = $clog2(DEPTH + 1);
    localparam int unsigned AW    = BUF_NUM_WIDTH + MEM_BUF_SHIFT;
    localparam int unsigned TW    = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATCH,
        ST_HDR,
        ST_READ,
        ST_DRAIN,
        ST_RELEASE,
        ST_WAIT_ACK
    } state_t;

    state_t                     state_q;
    logic [BUF_NUM_WIDTH-1:0]   rnum_q;
    logic [CW-1:0]              cnt_q;
    logic [MEM_BUF_SHIFT-1:0]   idx_q;
    logic [TW-1:0]              ack_cnt_q;
    logic                       mem_en_q;
    logic                       mem_last_q;
    logic [AW-1:0]              mem_addr_q;
    logic                       release_q;
    logic [BUF_NUM_WIDTH-1:0]   rel_bufnum_q;
    logic                       busy_q;
    logic                       ack_err_q;
`ifdef MUON_RDOUT_HDR_EN
    logic [31:0]                tag_a_q;
    logic [31:0]                tag_b_q;
    logic                       hdr_sel_q;
`else
    logic                       unused_tags;
`endif

    // read-data pipeline tracking which cycles carry valid memory data
    logic [MEM_LATENCY-1:0]     pipe_v;
    logic [MEM_LATENCY-1:0]     pipe_last;

    // output FIFO: {last, data}
    logic [64:0]                fifo_mem [DEPTH];
    logic [PW-1:0]              wr_ptr;
    logic [PW-1:0]              rd_ptr;
    logic [FCW-1:0]             fifo_cnt;
    logic [64:0]                head;

    logic                       pop;
    logic                       cap;
    logic                       push;
    logic [64:0]                push_word;
    logic                       hdr_push;
    logic [64:0]                hdr_word;
    logic                       last_issue;
    logic                       can_issue;
    logic [CW-1:0]              wc_clamped;
    int unsigned                free_slots;
    int unsigned                in_flight;

`ifndef MUON_RDOUT_HDR_EN
    assign unused_tags = ^{TIME_TAG_A, TIME_TAG_B};
`endif

    assign head      = fifo_mem[rd_ptr];
    assign OUT_VALID = (fifo_cnt != '0);
    assign OUT_DATA  = head[63:0];
    assign OUT_LAST  = OUT_VALID & head[64];

    assign MEM_EN         = mem_en_q;
    assign MEM_ADDR       = mem_addr_q;
    assign RELEASE        = release_q;
    assign RELEASE_BUFNUM = rel_bufnum_q;
    assign BUSY           = busy_q;
    assign ACK_ERR        = ack_err_q;

    // FIFO push/pop decisions and read-issue credit check
    always_comb begin
        pop        = OUT_VALID & OUT_READY;
        cap        = pipe_v[MEM_LATENCY-1];
        hdr_push   = 1'b0;
        hdr_word   = '0;
`ifdef MUON_RDOUT_HDR_EN
        hdr_push   = (state_q == ST_HDR) && (fifo_cnt != FCW'(DEPTH));
        hdr_word   = hdr_sel_q ? {(cnt_q == '0), 32'(cnt_q), tag_b_q}
                               : {1'b0, 32'hA5A5_0000 | 32'(rnum_q), tag_a_q};
`endif
        push       = cap | hdr_push;
        push_word  = hdr_push ? hdr_word : {pipe_last[MEM_LATENCY-1], MEM_DATA1, MEM_DATA0};
        wc_clamped = (BUF_WORD_COUNT > WC_WIDTH'(WMAX)) ? CW'(WMAX) : CW'(BUF_WORD_COUNT);
        last_issue = ({1'b0, idx_q} == (cnt_q - CW'(1)));
        // A word popped this cycle frees its slot in time for a read issued now,
        // which is what lets the stream sustain one word per cycle.
        free_slots = DEPTH - 32'(fifo_cnt) + 32'(pop);
        in_flight  = 32'($countones(pipe_v)) + 32'(mem_en_q);
        can_issue  = (free_slots > in_flight);
    end

    // shift read-valid and last flags along the memory latency
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            pipe_v    <= '0;
            pipe_last <= '0;
        end else begin
            pipe_v[0]    <= mem_en_q;
            pipe_last[0] <= mem_en_q & mem_last_q;
            for (int unsigned i = 1; i < MEM_LATENCY; i++) begin
                pipe_v[i]    <= pipe_v[i-1];
                pipe_last[i] <= pipe_last[i-1];
            end
        end
    end

    // output FIFO storage and pointers
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= push_word;
                wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // readout sequencer with registered memory, release and status outputs
    always_ff @(posedge CLK120 or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            rnum_q       <= '0;
            cnt_q        <= '0;
            idx_q        <= '0;
            ack_cnt_q    <= '0;
            mem_en_q     <= 1'b0;
            mem_last_q   <= 1'b0;
            mem_addr_q   <= '0;
            release_q    <= 1'b0;
            rel_bufnum_q <= '0;
            busy_q       <= 1'b0;
            ack_err_q    <= 1'b0;
`ifdef MUON_RDOUT_HDR_EN
            tag_a_q      <= '0;
            tag_b_q      <= '0;
            hdr_sel_q    <= 1'b0;
`endif
        end else begin
            release_q <= 1'b0;
            mem_en_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (ENABLE && (BUF_NFULL != '0)) begin
                        state_q <= ST_LATCH;
                        busy_q  <= 1'b1;
                    end
                end
                ST_LATCH: begin
                    rnum_q <= BUF_RNUM;
                    cnt_q  <= wc_clamped;
                    idx_q  <= '0;
`ifdef MUON_RDOUT_HDR_EN
                    tag_a_q   <= TIME_TAG_A;
                    tag_b_q   <= TIME_TAG_B;
                    hdr_sel_q <= 1'b0;
                    state_q   <= ST_HDR;
`else
                    if (wc_clamped == '0) begin
                        state_q      <= ST_RELEASE;
                        release_q    <= 1'b1;
                        rel_bufnum_q <= BUF_RNUM;
                    end else begin
                        state_q <= ST_READ;
                    end
`endif
                end
`ifdef MUON_RDOUT_HDR_EN
                ST_HDR: begin
                    if (hdr_push) begin
                        hdr_sel_q <= 1'b1;
                        if (hdr_sel_q) begin
                            state_q <= (cnt_q == '0) ? ST_DRAIN : ST_READ;
                        end
                    end
                end
`endif
                ST_READ: begin
                    if (can_issue) begin
                        mem_en_q   <= 1'b1;
                        mem_addr_q <= {rnum_q, idx_q};
                        mem_last_q <= last_issue;
                        idx_q      <= idx_q + 1'b1;
                        if (last_issue) begin
                            state_q <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pop && OUT_LAST) begin
                        state_q      <= ST_RELEASE;
                        release_q    <= 1'b1;
                        rel_bufnum_q <= rnum_q;
                    end
                end
                ST_RELEASE: begin
                    state_q   <= ST_WAIT_ACK;
                    ack_cnt_q <= '0;
                end
                ST_WAIT_ACK: begin
                    if (BUF_RNUM != rnum_q) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (ack_cnt_q == TW'(ACK_TIMEOUT - 1)) begin
                        ack_err_q <= 1'b1;
                        state_q   <= ST_IDLE;
                        busy_q    <= 1'b0;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muon_buf_readout_ctrl.sv
// Testbench for muon_buf_readout_ctrl: table-driven buffer readouts, random
// buffers against a queue-based reference model, plus hand-written sequences
// for ack timeout, wrap and reset during a read.
module tb_muon_buf_readout_ctrl;

    localparam int unsigned BNW   = 2;
    localparam int unsigned SHIFT = 11;
    localparam int unsigned WCW   = 12;
    localparam int unsigned LAT   = 2;
    localparam int unsigned TMO   = 1023;
    localparam int unsigned WMAX  = 1 << SHIFT;
    localparam int unsigned NBUF  = 1 << BNW;
`ifdef MUON_RDOUT_HDR_EN
    localparam int unsigned HDR_WORDS = 2;
`else
    localparam int unsigned HDR_WORDS = 0;
`endif

    logic                 CLK120 = 1'b0;
    logic                 RESET_N = 1'b0;
    logic                 ENABLE = 1'b0;
    logic [BNW:0]         BUF_NFULL = '0;
    logic [BNW-1:0]       BUF_RNUM = '0;
    logic [WCW-1:0]       BUF_WORD_COUNT = '0;
    logic [31:0]          TIME_TAG_A = '0;
    logic [31:0]          TIME_TAG_B = '0;
    logic                 MEM_EN;
    logic [BNW+SHIFT-1:0] MEM_ADDR;
    logic [31:0]          MEM_DATA0 = '0;
    logic [31:0]          MEM_DATA1 = '0;
    logic [63:0]          OUT_DATA;
    logic                 OUT_VALID;
    logic                 OUT_READY = 1'b0;
    logic                 OUT_LAST;
    logic                 RELEASE;
    logic [BNW-1:0]       RELEASE_BUFNUM;
    logic                 BUSY;
    logic                 ACK_ERR;

    int unsigned passed = 0;
    int unsigned total  = 0;

    always #5 CLK120 = ~CLK120;

    muon_buf_readout_ctrl #(
        .BUF_NUM_WIDTH (BNW),
        .MEM_BUF_SHIFT (SHIFT),
        .WC_WIDTH      (WCW),
        .MEM_LATENCY   (LAT),
        .ACK_TIMEOUT   (TMO)
    ) dut (
        .CLK120         (CLK120),
        .RESET_N        (RESET_N),
        .ENABLE         (ENABLE),
        .BUF_NFULL      (BUF_NFULL),
        .BUF_RNUM       (BUF_RNUM),
        .BUF_WORD_COUNT (BUF_WORD_COUNT),
        .TIME_TAG_A     (TIME_TAG_A),
        .TIME_TAG_B     (TIME_TAG_B),
        .MEM_EN         (MEM_EN),
        .MEM_ADDR       (MEM_ADDR),
        .MEM_DATA0      (MEM_DATA0),
        .MEM_DATA1      (MEM_DATA1),
        .OUT_DATA       (OUT_DATA),
        .OUT_VALID      (OUT_VALID),
        .OUT_READY      (OUT_READY),
        .OUT_LAST       (OUT_LAST),
        .RELEASE        (RELEASE),
        .RELEASE_BUFNUM (RELEASE_BUFNUM),
        .BUSY           (BUSY),
        .ACK_ERR        (ACK_ERR)
    );

    // memory contents as a pure function of word address
    function automatic logic [31:0] mem0(input logic [BNW+SHIFT-1:0] a);
        return (32'(a) * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction

    function automatic logic [31:0] mem1(input logic [BNW+SHIFT-1:0] a);
        return ((32'(a) << 7) ^ 32'hDEAD_BEEF) + 32'(a);
    endfunction

    // two-cycle read port; junk is driven whenever no read result is due
    logic                 mv1;
    logic [BNW+SHIFT-1:0] ma1;
    always @(posedge CLK120) begin
        mv1 <= MEM_EN;
        ma1 <= MEM_ADDR;
        if (mv1 === 1'b1) begin
            MEM_DATA0 <= mem0(ma1);
            MEM_DATA1 <= mem1(ma1);
        end else begin
            MEM_DATA0 <= $urandom;
            MEM_DATA1 <= $urandom;
        end
    end

    task automatic check(input string name, input logic [71:0] got, input logic [71:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, got, exp);
    endtask

    // One buffer: loader presents it, bench consumes the stream, acks after
    // ack_delay cycles (negative = never ack).
    task automatic run_buffer(input int unsigned rnum, input int unsigned wc,
                              input int unsigned rmode, input int ack_delay,
                              input bit scramble, input bit drop_en,
                              input logic [31:0] ta, input logic [31:0] tb_tag,
                              input int unsigned exp_words, input string tag);
        int unsigned      cnt;
        logic [64:0]      expq[$];
        int unsigned      addrq[$];
        logic [64:0]      w;
        logic [64:0]      held_w;
        bit               held;
        bit               released;
        bit               done;
        int               cyc;
        int               rel_cyc;
        int               first_acc;
        int               last_acc;
        int unsigned      nwords;
        int unsigned      rel_count;
        int unsigned      busy_cnt;
        int               budget;
        int unsigned      a;

        cnt = (wc > WMAX) ? WMAX : wc;
`ifdef MUON_RDOUT_HDR_EN
        expq.push_back({1'(cnt == 0), 32'hA5A5_0000 | 32'(rnum), ta});
        expq.push_back({1'(cnt == 0), 32'(cnt), tb_tag});
`endif
        for (int unsigned i = 0; i < cnt; i++) begin
            a = rnum * WMAX + i;
            addrq.push_back(a);
            expq.push_back({1'(i == cnt - 1), mem1(13'(a)), mem0(13'(a))});
        end

        held = 0; released = 0; done = 0; cyc = 0; rel_cyc = 0;
        first_acc = -1; last_acc = -1; nwords = 0; rel_count = 0; busy_cnt = 0;
        held_w = '0;
        budget = 4 * int'(cnt) + 300 + ((ack_delay < 0) ? int'(TMO) + 50 : ack_delay);

        BUF_RNUM       = BNW'(rnum);
        BUF_WORD_COUNT = WCW'(wc);
        TIME_TAG_A     = ta;
        TIME_TAG_B     = tb_tag;
        BUF_NFULL      = 1;
        ENABLE         = 1'b1;

        while (!done && cyc < budget) begin
            @(negedge CLK120);
            cyc++;
            if (held) begin
                check({tag, "_stall_hold"}, 72'({OUT_VALID, OUT_LAST, OUT_DATA}), 72'({1'b1, held_w}));
                held = 0;
            end
            if (BUSY) busy_cnt++;
            if (scramble && busy_cnt == 2) begin
                BUF_WORD_COUNT = WCW'($urandom);
                TIME_TAG_A     = $urandom;
                TIME_TAG_B     = $urandom;
                BUF_NFULL      = (BNW+1)'($urandom_range(1, NBUF));
            end
            if (drop_en && busy_cnt == 3) ENABLE = 1'b0;

            if (MEM_EN) begin
                if (addrq.size() == 0) check({tag, "_mem_en_extra"}, 72'(MEM_EN), 72'(0));
                else check({tag, "_mem_addr"}, 72'(MEM_ADDR), 72'(addrq.pop_front()));
            end

            case (rmode)
                0:       OUT_READY = 1'b1;
                1:       OUT_READY = cyc[0];
                default: OUT_READY = 1'($urandom_range(0, 1));
            endcase

            if (OUT_VALID) begin
                if (OUT_READY) begin
                    if (expq.size() == 0) begin
                        check({tag, "_out_extra"}, 72'(OUT_VALID), 72'(0));
                    end else begin
                        w = expq.pop_front();
                        check({tag, "_out_word"}, 72'({OUT_LAST, OUT_DATA}), 72'(w));
                    end
                    nwords++;
                    if (nwords == HDR_WORDS + 1) first_acc = cyc;
                    if (nwords > HDR_WORDS) last_acc = cyc;
                end else begin
                    held   = 1;
                    held_w = {OUT_LAST, OUT_DATA};
                end
            end

            if (RELEASE) begin
                rel_count++;
                check({tag, "_release_bufnum"}, 72'(RELEASE_BUFNUM), 72'(rnum));
                check({tag, "_release_after_words"}, 72'(expq.size()), 72'(0));
                if (!released) begin
                    released = 1;
                    rel_cyc  = cyc;
                    if (ack_delay < 0) BUF_NFULL = 0;
                end
            end

            if (released && ack_delay >= 0) begin
                if (cyc == rel_cyc + ack_delay) begin
                    check({tag, "_busy_wait_ack"}, 72'(BUSY), 72'(1));
                    BUF_RNUM  = BNW'((rnum + 1) % NBUF);
                    BUF_NFULL = 0;
                end else if (cyc > rel_cyc + ack_delay && !BUSY) begin
                    done = 1;
                end
            end
            if (released && ack_delay < 0) begin
                if (cyc == rel_cyc + int'(TMO) - 23)
                    check({tag, "_ack_err_early"}, 72'(ACK_ERR), 72'(0));
                if (cyc == rel_cyc + int'(TMO) + 7) begin
                    check({tag, "_ack_err_set"}, 72'(ACK_ERR), 72'(1));
                    check({tag, "_idle_after_timeout"}, 72'(BUSY), 72'(0));
                    done = 1;
                end
            end
        end

        check({tag, "_completed"}, 72'(done), 72'(1));
        check({tag, "_words"}, 72'(nwords), 72'(exp_words));
        check({tag, "_reads_issued"}, 72'(addrq.size()), 72'(0));
        check({tag, "_release_count"}, 72'(rel_count), 72'(1));
        if (ack_delay >= 0) check({tag, "_ack_err_clear"}, 72'(ACK_ERR), 72'(0));
        if (rmode == 0 && cnt > 1)
            check({tag, "_back_to_back"}, 72'(last_acc - first_acc), 72'(cnt - 1));
        ENABLE    = 1'b1;
        OUT_READY = 1'b0;
    endtask

    typedef struct {
        int unsigned rnum;
        int unsigned wc;
        int unsigned rmode;
        int          ack_delay;
        int unsigned exp_data_words;
    } vec_t;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t        tbl[8];
        int unsigned wc;
        bit          found;

        tbl[0] = '{0, 4,    0, 2,  4};
        tbl[1] = '{1, 8,    1, 0,  8};
        tbl[2] = '{3, 2,    0, 3,  2};
        tbl[3] = '{2, 0,    0, 1,  0};
        tbl[4] = '{1, 1,    2, 5,  1};
        tbl[5] = '{0, 4095, 0, 0,  2048};
        tbl[6] = '{2, 2048, 1, 4,  2048};
        tbl[7] = '{3, 17,   2, 7,  17};

        repeat (3) @(negedge CLK120);
        check("reset_ctrl", 72'({MEM_EN, MEM_ADDR, OUT_VALID, OUT_LAST, RELEASE,
                                 RELEASE_BUFNUM, BUSY, ACK_ERR}), 72'(0));
        check("reset_data", 72'(OUT_DATA), 72'(0));
        RESET_N = 1'b1;
        @(negedge CLK120);

        // ENABLE low: a full buffer must not be started
        ENABLE = 1'b0;
        BUF_NFULL = 1;
        repeat (10) @(negedge CLK120);
        check("disabled_busy", 72'(BUSY), 72'(0));
        check("disabled_mem_en", 72'(MEM_EN), 72'(0));
        BUF_NFULL = 0;
        ENABLE = 1'b1;
        @(negedge CLK120);

        foreach (tbl[i]) begin
            run_buffer(tbl[i].rnum, tbl[i].wc, tbl[i].rmode, tbl[i].ack_delay, 0, 0,
                       $urandom, $urandom, tbl[i].exp_data_words + HDR_WORDS,
                       $sformatf("tbl%0d", i));
            @(negedge CLK120);
        end

`ifdef MUON_RDOUT_HDR_EN
        run_buffer(0, 0, 0, 2, 0, 0, 32'h100, 32'h200, 2, "hdr_zero");
        @(negedge CLK120);
`endif

        for (int r = 0; r < 12; r++) begin
            wc = $urandom_range(0, 40);
            run_buffer($urandom_range(0, NBUF - 1), wc, 2, int'($urandom_range(0, 15)), 1,
                       1'($urandom_range(0, 1)), $urandom, $urandom,
                       ((wc > WMAX) ? WMAX : wc) + HDR_WORDS, $sformatf("rnd%0d", r));
            @(negedge CLK120);
        end

        run_buffer(1, 3, 0, -1, 0, 0, $urandom, $urandom, 3 + HDR_WORDS, "timeout");
        repeat (5) @(negedge CLK120);
        check("ack_err_sticky", 72'(ACK_ERR), 72'(1));
        check("idle_after_sticky", 72'(BUSY), 72'(0));

        // reset in the middle of a read burst
        BUF_RNUM = 2;
        BUF_WORD_COUNT = 16;
        OUT_READY = 1'b1;
        BUF_NFULL = 1;
        found = 0;
        for (int c = 0; c < 100 && !found; c++) begin
            @(negedge CLK120);
            if (MEM_EN && MEM_ADDR == 13'(2 * WMAX + 5)) found = 1;
        end
        check("midread_reached", 72'(found), 72'(1));
        check("midread_valid_before_reset", 72'(OUT_VALID), 72'(1));
        BUF_NFULL = 0;
        RESET_N = 1'b0;
        #1;
        check("midread_reset_outs", 72'({OUT_VALID, MEM_EN, RELEASE, BUSY, ACK_ERR}), 72'(0));
        @(negedge CLK120);
        RESET_N = 1'b1;
        repeat (3) @(negedge CLK120);
        check("after_reset_idle", 72'({BUSY, OUT_VALID, MEM_EN}), 72'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
